// File: rtl/cla_subtractor_seq.sv
// Iterative wide subtractor: computes A - B - BIN one 4-bit carry-lookahead
// slice per clock, with the inter-slice carry held in a register.
module cla_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic             ZERO,
  output logic             OVF
);

  localparam int NSLICE = WIDTH / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int MSB    = WIDTH - 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last;
  logic [3:0]       sa, sb, sp, sg, nib;
  logic [4:0]       c;

  assign accept = (state_q == IDLE) && START;
  assign last   = (k_q == K_LAST);

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, regardless of block order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (START) state_d = RUN;
      RUN:     if (last)  state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    READY = (state_q == IDLE);
    DONE  = (state_q == FIN);
  end

  // ---------------------------------------------------------- slice CLA
  // Select the current nibble of A and of the inverted B.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (k_q == KW'(i)) begin
        sa = a_q[4*i +: 4];
        sb = ~b_q[4*i +: 4];
      end
    end
  end

  assign sp   = sa ^ sb;
  assign sg   = sa & sb;
  assign c[0] = carry_q;
  assign c[1] = sg[0] | (sp[0] & c[0]);
  assign c[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & c[0]);
  assign c[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
              | (sp[2] & sp[1] & sp[0] & c[0]);
  assign c[4] = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
              | (sp[3] & sp[2] & sp[1] & sg[0])
              | (sp[3] & sp[2] & sp[1] & sp[0] & c[0]);
  assign nib  = sp ^ c[3:0];

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    work_d = work_q;
    for (int i = 0; i < NSLICE; i++) begin
      if (k_q == KW'(i)) work_d[4*i +: 4] = nib;
    end
  end

  // ------------------------------------------------------------ datapath
  // NOTE: operand and working-result registers carry no reset; they are
  // always written before being read, so resetting them buys nothing.
  always_ff @(posedge CLK) begin
    if (accept) begin
      a_q <= A;
      b_q <= B;
    end
    if (state_q == RUN) work_q <= work_d;
  end

  always_comb begin
    carry_d = carry_q;
    k_d     = k_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    if (accept) begin
      carry_d = ~BIN;
      k_d     = '0;
    end else if (state_q == RUN) begin
      carry_d = c[4];
      k_d     = k_q + 1'b1;
      if (last) begin
        diff_d = work_d;
        bout_d = ~c[4];
        zero_d = (work_d == '0);
        ovf_d  = (a_q[MSB] != b_q[MSB]) && (work_d[MSB] != a_q[MSB]);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      carry_q <= 1'b0;
      k_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      k_q     <= k_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign DIFF = diff_q;
  assign BOUT = bout_q;
  assign ZERO = zero_q;
  assign OVF  = ovf_q;

endmodule
